// File: rtl/rtp_tx_arbiter.sv
// rtp_tx_arbiter
// Packet-granular scheduler that shares one Ethernet transmit path between the
// video RTP stream and the audio RTP stream. Whole packets are granted, so the
// streams never interleave mid-packet. Audio has priority, and a streak counter
// forces a video grant after AUD_BURST_MAX audio packets while video waits. A
// programmable inter-packet gap follows every packet.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   vid_data/valid/last, vid_ready   video RTP beat input (valid/ready)
//   aud_data/valid/last, aud_ready   audio RTP beat input (valid/ready)
//   eth_data/valid/last, eth_ready   beat output towards ethernet_tx
//   grant                            00 none, 01 video, 10 audio
//   busy                             high in any state other than IDLE
//
// Optional feature (macro RTP_ARB_STATS_EN):
//   vid_pkt_cnt, aud_pkt_cnt         wrapping 16-bit completed-packet counters
//   starve_evt                       1-cycle pulse when video is forced by the streak limit
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no grant; arbitration decision taken here, registered
// GRANT_V | video packet passes through to eth_*
// GRANT_A | audio packet passes through to eth_*
// GAP     | inter-packet gap, all ready low, eth_valid low

module rtp_tx_arbiter #(
  parameter int DATA_W        = 32,
  parameter int IPG_CYCLES    = 3,
  parameter int AUD_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_valid,
  input  logic              vid_last,
  output logic              vid_ready,
  input  logic [DATA_W-1:0] aud_data,
  input  logic              aud_valid,
  input  logic              aud_last,
  output logic              aud_ready,
  output logic [DATA_W-1:0] eth_data,
  output logic              eth_valid,
  output logic              eth_last,
  input  logic              eth_ready,
  output logic [1:0]        grant,
  output logic              busy
`ifdef RTP_ARB_STATS_EN
  ,
  output logic [15:0]       vid_pkt_cnt,
  output logic [15:0]       aud_pkt_cnt,
  output logic              starve_evt
`endif
);

  localparam int STREAK_W = $clog2(AUD_BURST_MAX + 1);
  localparam int GAP_W    = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(AUD_BURST_MAX);
  // Only meaningful when IPG_CYCLES > 0; the GAP state is unreachable otherwise.
  localparam logic [GAP_W-1:0] GAP_LOAD = (IPG_CYCLES > 0) ? GAP_W'(IPG_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_V = 2'd1,
    GRANT_A = 2'd2,
    GAP     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                vid_done, aud_done;

  assign vid_done = vid_valid & vid_ready & vid_last;
  assign aud_done = aud_valid & aud_ready & aud_last;

`ifdef RTP_ARB_STATS_EN
  logic        starve_d, starve_q;
  logic [15:0] vid_pkt_cnt_q, vid_pkt_cnt_d;
  logic [15:0] aud_pkt_cnt_q, aud_pkt_cnt_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    gap_cnt_d = gap_cnt_q;
`ifdef RTP_ARB_STATS_EN
    starve_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (aud_valid && vid_valid) begin
          // streak only grows while video is waiting, so it saturates here
          if (streak_q < STREAK_MAX) begin
            state_d  = GRANT_A;
            streak_d = streak_q + 1'b1;
          end else begin
            state_d  = GRANT_V;
            streak_d = '0;
`ifdef RTP_ARB_STATS_EN
            starve_d = 1'b1;
`endif
          end
        end else if (aud_valid) begin
          state_d  = GRANT_A;
          streak_d = '0;
        end else if (vid_valid) begin
          state_d  = GRANT_V;
          streak_d = '0;
        end
      end
      GRANT_V: begin
        if (vid_done) begin
          if (IPG_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GRANT_A: begin
        if (aud_done) begin
          if (IPG_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: zero-latency pass-through of the granted stream
  always_comb begin
    eth_data  = '0;
    eth_valid = 1'b0;
    eth_last  = 1'b0;
    vid_ready = 1'b0;
    aud_ready = 1'b0;
    grant     = 2'b00;
    case (state_q)
      GRANT_V: begin
        eth_data  = vid_data;
        eth_valid = vid_valid;
        eth_last  = vid_last;
        vid_ready = eth_ready;
        grant     = 2'b01;
      end
      GRANT_A: begin
        eth_data  = aud_data;
        eth_valid = aud_valid;
        eth_last  = aud_last;
        aud_ready = eth_ready;
        grant     = 2'b10;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef RTP_ARB_STATS_EN
  always_comb begin
    vid_pkt_cnt_d = vid_done ? vid_pkt_cnt_q + 16'd1 : vid_pkt_cnt_q;
    aud_pkt_cnt_d = aud_done ? aud_pkt_cnt_q + 16'd1 : aud_pkt_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_pkt_cnt_q <= '0;
      aud_pkt_cnt_q <= '0;
      starve_q      <= 1'b0;
    end else begin
      vid_pkt_cnt_q <= vid_pkt_cnt_d;
      aud_pkt_cnt_q <= aud_pkt_cnt_d;
      starve_q      <= starve_d;
    end
  end

  assign vid_pkt_cnt = vid_pkt_cnt_q;
  assign aud_pkt_cnt = aud_pkt_cnt_q;
  assign starve_evt  = starve_q;
`endif

endmodule
